mix_columns_engine: RTL and testbench
=====================================

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, meaning AES state columns transformed per clock; legal values 1, 2 and 4; any other value SHALL fail elaboration.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic SHALL be rising-edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning a state is offered.
REQ-005 SHALL have port in_ready, output, 1, meaning the engine accepts the offered state this cycle.
REQ-006 SHALL have port mode, input, 2: 00 = MixColumns, 01 = InvMixColumns, 1x = bypass.
REQ-007 SHALL have port in_data, input, 128, the AES state; column c is bits [127-32c -: 32], and row 0 of each column is its MSB byte.
REQ-008 SHALL have port out_valid, output, 1, meaning out_data holds a result.
REQ-009 SHALL have port out_ready, input, 1, meaning the downstream consumer takes the result.
REQ-010 SHALL have port out_data, output, 128, the result in the same byte layout as in_data.
REQ-011 SHALL have port busy, output, 1, high whenever the engine is not in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 Accept SHALL occur when in_valid and in_ready are both high at a rising edge; in_data and mode SHALL be captured at that edge.
REQ-014 IDLE -> BUSY SHALL occur on accept; the column index SHALL be cleared to 0 on accept.
REQ-015 In BUSY, each cycle SHALL transform COLS_PER_CYCLE columns in place, starting at the current column index, which then advances by COLS_PER_CYCLE.
REQ-016 BUSY -> DONE SHALL occur when column 3 has been processed; out_valid SHALL be high in DONE.
REQ-017 Latency: out_valid SHALL rise exactly N = 4/COLS_PER_CYCLE cycles after the accept edge (N = 4, 2 or 1).
REQ-018 Forward mode SHALL use GF(2^8) polynomial x^8+x^4+x^3+x+1 with matrix rows [02 03 01 01], rotated per row.
REQ-019 Inverse mode SHALL use the matrix rows [0e 0b 0d 09], rotated per row.
REQ-020 Bypass mode SHALL return in_data unchanged, with identical latency and handshake.
REQ-021 Changes on mode or in_data after accept SHALL NOT affect the in-flight result.
REQ-022 out_data and out_valid SHALL hold stable in DONE until out_ready is high.
REQ-023 DONE with out_ready high and no new accept SHALL go to IDLE.
REQ-024 in_ready SHALL be high in IDLE, and in DONE when out_ready is high; it SHALL be low in BUSY.
REQ-025 DONE with out_ready and in_valid both high SHALL retire the result and accept the new state in the same cycle (-> BUSY), with no bubble.
REQ-026 in_valid high while in BUSY SHALL be ignored and SHALL NOT be lost by the source: the source holds the request because in_ready is low.
REQ-027 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-028 While rst is high at a rising edge, the FSM SHALL go to IDLE and the column index SHALL go to 0.
REQ-029 While rst is high at a rising edge, out_valid SHALL go to 0, busy SHALL go to 0 and out_data SHALL go to 0.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-031 rst asserted mid-BUSY or in DONE SHALL abort the operation, with no out_valid pulse afterwards.
REQ-032 rst SHALL take priority over simultaneous accept or retire.

Verification
REQ-033 Forward test (COLS_PER_CYCLE = 1, 2 and 4): mode=00, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=046681e5e0cb199a48f8d37a2806264c, with out_valid rising exactly 4, 2 and 1 cycles after accept respectively.
REQ-034 Inverse test: mode=01, in_data=046681e5e0cb199a48f8d37a2806264c -> out_data=d4bf5d30e0b452aeb84111f11e2798e5.
REQ-035 Column vectors, forward mode: db135345f20a225c01010101c6c6c6c6 -> 8e4da1bc9fdc589d01010101c6c6c6c6; the inverse of that output SHALL restore the input.
REQ-036 Backpressure test: hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0 throughout; then raise out_ready and in_valid together with mode=10 and in_data=00112233445566778899aabbccddeeff -> back-to-back accept, and the next output equals the input after N cycles.
REQ-037 Reset test: pulse rst during cycle 2 of a COLS_PER_CYCLE=1 operation -> out_valid never rises, busy=0 and in_ready=1 the cycle after rst deasserts.
REQ-038 Mode-change test: toggle mode and in_data every cycle during BUSY -> result equals the value captured at accept.

Source files
------------

// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine with valid/ready handshakes.
// The captured state is transformed in place, COLS_PER_CYCLE columns per clock.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Column index wraps modulo 4, so a step of 4 is a step of 0.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

    logic [1:0]   state_p0;
    logic [1:0]   col_p0;
    logic [1:0]   mode_p0;
    logic [127:0] work_p0;
    logic [127:0] work_nxt;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the forward or inverse matrix; every row is the
    // first row rotated right, so a single set of four multiples suffices.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] f0 [4];
        logic [7:0] f1 [4];
        logic [7:0] f2 [4];
        logic [7:0] f3 [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a[i] = c[31 - 8*i -: 8];
            x2 = xtime(a[i]);
            x4 = xtime(x2);
            x8 = xtime(x4);
            if (inv) begin
                f0[i] = x8 ^ x4 ^ x2;
                f1[i] = x8 ^ x2 ^ a[i];
                f2[i] = x8 ^ x4 ^ a[i];
                f3[i] = x8 ^ a[i];
            end else begin
                f0[i] = x2;
                f1[i] = x2 ^ a[i];
                f2[i] = a[i];
                f3[i] = a[i];
            end
        end
        for (int row = 0; row < 4; row++) begin
            r[31 - 8*row -: 8] = f0[2'(row)] ^ f1[2'(row + 1)] ^ f2[2'(row + 2)] ^ f3[2'(row + 3)];
        end
        return r;
    endfunction

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state_p0 == IDLE) || ((state_p0 == DONE) && out_ready);
    assign out_valid = (state_p0 == DONE);
    assign busy      = (state_p0 != IDLE);
    assign out_data  = work_p0;

    always_comb begin
        logic [1:0] lane;
        int         base;
        lane     = '0;
        base     = 0;
        work_nxt = work_p0;
        if (!mode_p0[1]) begin
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                lane = col_p0 + 2'(k);
                base = 96 - 32 * int'(lane);
                work_nxt[base +: 32] = mix_col(work_p0[base +: 32], mode_p0[0]);
            end
        end
    end

    // Stage p0: control state, column index and working state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            col_p0   <= '0;
            mode_p0  <= '0;
            work_p0  <= '0;
        end else begin
            case (state_p0)
                IDLE: begin
                    if (accept) state_p0 <= BUSY;
                end
                BUSY: begin
                    work_p0 <= work_nxt;
                    col_p0  <= col_p0 + COL_STEP;
                    if (col_p0 == COL_LAST) state_p0 <= DONE;
                end
                DONE: begin
                    if (accept)         state_p0 <= BUSY;
                    else if (out_ready) state_p0 <= IDLE;
                end
                default: state_p0 <= IDLE;
            endcase
            if (accept) begin
                col_p0  <= '0;
                mode_p0 <= mode;
                work_p0 <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: one instance per COLS_PER_CYCLE value (1, 2, 4),
// directed AES vectors plus random states checked against a GF(2^8) matrix model.
module tb_mix_columns_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         iv   [3];
    logic         ir   [3];
    logic [1:0]   md   [3];
    logic [127:0] id   [3];
    logic         ov   [3];
    logic         ordy [3];
    logic [127:0] od   [3];
    logic         bz   [3];

    int checks   = 0;
    int failures = 0;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (iv[g]),
                .in_ready  (ir[g]),
                .mode      (md[g]),
                .in_data   (id[g]),
                .out_valid (ov[g]),
                .out_ready (ordy[g]),
                .out_data  (od[g]),
                .busy      (bz[g])
            );
        end
    endgenerate

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [1:0] m, input logic [127:0] d);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (m[1]) return d;
        if (m[0]) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else      coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(coef[2'(j - row)], d[127 - 32*c - 8*j -: 8]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; scrambles inputs during BUSY and
    // leaves the instance in DONE with inputs idle.
    task automatic wait_result(input int u, input logic [127:0] exp, input string tag);
        int lat;
        lat = 0;
        chk({tag, "_busy"}, 128'(bz[u]), 128'(1));
        chk({tag, "_rdy_busy"}, 128'(ir[u]), 128'(0));
        while (!ov[u] && lat < 16) begin
            iv[u] = 1'($urandom);
            md[u] = 2'($urandom);
            id[u] = {$urandom, $urandom, $urandom, $urandom};
            tick();
            lat++;
        end
        iv[u] = 1'b0;
        chk({tag, "_lat"}, 128'(lat), 128'(4 >> u));
        chk({tag, "_data"}, od[u], exp);
    endtask

    task automatic run_op(input int u, input logic [1:0] m, input logic [127:0] d,
                          input logic [127:0] exp, input string tag);
        chk({tag, "_rdy_idle"}, 128'(ir[u]), 128'(1));
        iv[u] = 1'b1;
        md[u] = m;
        id[u] = d;
        tick();
        iv[u] = 1'b0;
        wait_result(u, exp, tag);
    endtask

    task automatic retire(input int u, input string tag);
        ordy[u] = 1'b1;
        #1;
        chk({tag, "_rdy_done"}, 128'(ir[u]), 128'(1));
        tick();
        chk({tag, "_ov_clear"}, 128'(ov[u]), 128'(0));
        chk({tag, "_rdy_after"}, 128'(ir[u]), 128'(1));
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] held;
        logic [1:0]   m;

        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            iv[u] = 1'b0; md[u] = 2'b00; id[u] = '0; ordy[u] = 1'b1;
        end
        repeat (3) tick();
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_ov%0d", u), 128'(ov[u]), 128'(0));
            chk($sformatf("rst_busy%0d", u), 128'(bz[u]), 128'(0));
            chk($sformatf("rst_data%0d", u), od[u], 128'(0));
        end
        rst = 1'b0;
        tick();
        for (int u = 0; u < 3; u++) chk($sformatf("rst_rdy%0d", u), 128'(ir[u]), 128'(1));

        // Directed AES vectors on every width
        for (int u = 0; u < 3; u++) begin
            run_op(u, 2'b00, 128'hd4bf5d30e0b452aeb84111f11e2798e5,
                   128'h046681e5e0cb199a48f8d37a2806264c, $sformatf("fwd%0d", u));
            retire(u, $sformatf("fwd%0d", u));
            run_op(u, 2'b01, 128'h046681e5e0cb199a48f8d37a2806264c,
                   128'hd4bf5d30e0b452aeb84111f11e2798e5, $sformatf("inv%0d", u));
            retire(u, $sformatf("inv%0d", u));
            run_op(u, 2'b00, 128'hdb135345f20a225c01010101c6c6c6c6,
                   128'h8e4da1bc9fdc589d01010101c6c6c6c6, $sformatf("colf%0d", u));
            retire(u, $sformatf("colf%0d", u));
            run_op(u, 2'b01, 128'h8e4da1bc9fdc589d01010101c6c6c6c6,
                   128'hdb135345f20a225c01010101c6c6c6c6, $sformatf("coli%0d", u));
            retire(u, $sformatf("coli%0d", u));
        end

        for (int u = 0; u < 3; u++) begin
            for (int t = 0; t < 8; t++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                m = 2'($urandom);
                run_op(u, m, d, model(m, d), $sformatf("rnd%0d_%0d", u, t));
                retire(u, $sformatf("rnd%0d_%0d", u, t));
            end
        end

        // Backpressure in DONE, then retire and accept on the same edge
        for (int u = 0; u < 3; u++) begin
            ordy[u] = 1'b0;
            d = {$urandom, $urandom, $urandom, $urandom};
            run_op(u, 2'b00, d, model(2'b00, d), $sformatf("bp%0d", u));
            held = od[u];
            for (int k = 0; k < 5; k++) begin
                tick();
                chk($sformatf("bp%0d_hold%0d", u, k), od[u], held);
                chk($sformatf("bp%0d_ov%0d", u, k), 128'(ov[u]), 128'(1));
                chk($sformatf("bp%0d_rdy%0d", u, k), 128'(ir[u]), 128'(0));
            end
            ordy[u] = 1'b1;
            iv[u] = 1'b1;
            md[u] = 2'b10;
            id[u] = 128'h00112233445566778899aabbccddeeff;
            #1;
            chk($sformatf("bp%0d_rdy_up", u), 128'(ir[u]), 128'(1));
            tick();
            iv[u] = 1'b0;
            chk($sformatf("bp%0d_b2b_ov", u), 128'(ov[u]), 128'(0));
            wait_result(u, 128'h00112233445566778899aabbccddeeff, $sformatf("bp%0d_byp", u));
            retire(u, $sformatf("bp%0d_byp", u));
        end

        // Reset during the second BUSY cycle of the one-column engine
        d = {$urandom, $urandom, $urandom, $urandom};
        iv[0] = 1'b1; md[0] = 2'b00; id[0] = d;
        tick();
        iv[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 128'(bz[0]), 128'(0));
        chk("abort_rdy", 128'(ir[0]), 128'(1));
        chk("abort_data", od[0], 128'(0));
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("abort_ov%0d", k), 128'(ov[0]), 128'(0));
            tick();
        end
        run_op(0, 2'b01, d, model(2'b01, d), "post_rst");
        retire(0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
